// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the dot-product sequencer and its mac datapath.
//   Holds the sequencer state encoding and the default operand width.
//   No ports (package).
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac.sv
// ---------------------------------------------------------------------------
// mac
//   Unsigned multiply-accumulate datapath. Every cycle the product a*b is
//   added to the accumulator, so a zero operand pair adds nothing. The
//   product passes through MAC_LAT-1 pipeline stages before the add, which
//   gives MAC_LAT cycles from an operand change to the matching result update.
//   The accumulator wraps modulo 2**(2*DATA_WIDTH).
// Ports
//   clk     in   1             rising-edge clock
//   rst     in   1             asynchronous, active-high clear of all state
//   a       in   DATA_WIDTH    operand A (unsigned)
//   b       in   DATA_WIDTH    operand B (unsigned)
//   result  out  2*DATA_WIDTH  accumulated sum
// ---------------------------------------------------------------------------
module mac #(
  parameter int DATA_WIDTH = 8,
  parameter int MAC_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] prod_last;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;

  assign prod = PW'(a) * PW'(b);

  generate
    if (MAC_LAT <= 1) begin : g_no_pipe
      assign prod_last = prod;
    end else begin : g_pipe
      logic [PW-1:0] pipe_q [MAC_LAT-1];

      // Product delay line; the accumulator add is always the final stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MAC_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= prod;
          for (int i = 1; i < MAC_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign prod_last = pipe_q[MAC_LAT-2];
    end
  endgenerate

  always_comb begin
    acc_d = acc_q + prod_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign result = acc_q;

endmodule

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq
//   Dot-product sequencer in front of one mac instance. A start strobe in
//   IDLE latches len and clears the accumulator; len operand pairs are then
//   accepted with valid/ready flow control. After the last pair the
//   sequencer waits out the datapath latency and presents the final sum
//   with a one-cycle res_valid pulse. res_data holds until the next job.
//   Optional feature macro: MAC_SEQ_OVF_EN builds a sticky wrap detector
//   driving ovf; without it ovf is tied low.
// Ports
//   clk        in   1             rising-edge clock
//   a_reset_n  in   1             asynchronous, active-low reset
//   start      in   1             command strobe, honoured only when idle
//   len        in   LEN_W         number of operand pairs, latched on start
//   busy       out  1             high whenever a job is in progress
//   in_valid   in   1             operand pair valid
//   in_ready   out  1             operand pair ready (RUN only)
//   in_a       in   DATA_WIDTH    operand A (unsigned)
//   in_b       in   DATA_WIDTH    operand B (unsigned)
//   res_valid  out  1             one-cycle pulse, res_data is final
//   res_data   out  2*DATA_WIDTH  final sum
//   ovf        out  1             sticky accumulator-wrap flag
// ---------------------------------------------------------------------------
module mac_seq
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_W      = 8,
  parameter int MAC_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    a_reset_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    res_valid,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    ovf
);

  localparam int PW      = 2 * DATA_WIDTH;
  localparam int DRAIN_W = $clog2(MAC_LAT + 1) + 1;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  clr_q, clr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic [PW-1:0]         res_data_q, res_data_d;
  logic [PW-1:0]         mac_result;
  logic                  mac_rst;

  // clr_q is a flop, so the datapath clear cannot glitch.
  assign mac_rst = clr_q | ~a_reset_n;

  mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAC_LAT    (MAC_LAT)
  ) u_mac (
    .clk    (clk),
    .rst    (mac_rst),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (mac_result)
  );

  // Operand registers load zero on every cycle without an accepted beat,
  // so bubbles and the drain phase add nothing to the sum. All outputs are
  // computed one state ahead and registered.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    clr_d       = 1'b0;
    op_a_d      = '0;
    op_b_d      = '0;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          len_d      = len;
          cnt_d      = '0;
          clr_d      = 1'b1;
          res_data_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (len_q == '0) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(MAC_LAT);
        end else begin
          state_d    = ST_RUN;
          in_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (in_valid && in_ready_q) begin
          op_a_d = in_a;
          op_b_d = in_b;
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) begin
            state_d    = ST_DRAIN;
            drain_d    = DRAIN_W'(MAC_LAT);
            in_ready_d = 1'b0;
          end
        end
      end
      // Counts MAC_LAT down to zero, i.e. MAC_LAT+1 cycles, so the last
      // product has reached the accumulator before DONE samples it.
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        res_data_d  = mac_result;
        res_valid_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      clr_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      clr_q       <= clr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef MAC_SEQ_OVF_EN
  logic [PW-1:0] prev_q, prev_d;
  logic          ovf_q, ovf_d;

  // Products are unsigned, so the sum only ever grows; a drop below the
  // previous value means the accumulator wrapped.
  always_comb begin
    prev_d = mac_result;
    ovf_d  = ovf_q;
    if (state_q == ST_IDLE && start) begin
      ovf_d = 1'b0;
    end else if ((state_q == ST_RUN || state_q == ST_DRAIN) &&
                 (mac_result < prev_q)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_seq
//   Self-checking bench for mac_seq. A job-level reference model tracks the
//   expected outputs from the accepted beats and the documented latency;
//   a compare process checks the DUT against it every cycle. Directed jobs
//   pin the model with hand-computed sums and latencies, then randomized
//   jobs exercise lengths, operands, bubbles and ignored start strobes.
//   Honours MAC_SEQ_OVF_EN for the expected ovf value.
// ---------------------------------------------------------------------------
module tb_mac_seq;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int ML = 1;
`ifdef MAC_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          a_reset_n = 1'b0;
  logic          start     = 1'b0;
  logic [LW-1:0] len       = '0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_a      = '0;
  logic [DW-1:0] in_b      = '0;
  logic          busy;
  logic          in_ready;
  logic          res_valid;
  logic [2*DW-1:0] res_data;
  logic          ovf;

  always #5 clk = ~clk;

  mac_seq #(
    .DATA_WIDTH (DW),
    .LEN_W      (LW),
    .MAC_LAT    (ML)
  ) dut (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_data  (res_data),
    .ovf       (ovf)
  );

  int checks = 0;
  int passes = 0;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
  endtask

  // Job-level reference model: a job accepts beats while fewer than len
  // have been taken, and the result appears MAC_LAT+2 edges after the last
  // beat (or after the clear edge for an empty job).
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_pulse = 1'b0;
  int          m_start = 0;
  int          m_len = 0;
  int          m_beats = 0;
  int          m_valid_edge = -1;
  longint      m_sum = 0;
  longint      m_res = 0;
  bit          m_ovf = 1'b0;

  task automatic modelStep();
    bit acc;
    if (!a_reset_n) begin
      m_busy = 0; m_ready = 0; m_pulse = 0; m_beats = 0; m_len = 0;
      m_valid_edge = -1; m_sum = 0; m_res = 0; m_ovf = 0;
    end else begin
      cyc++;
      m_pulse = 0;
      acc = m_ready && in_valid;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_start = cyc; m_len = int'(len); m_beats = 0;
          m_sum = 0; m_res = 0; m_ovf = 0;
          m_valid_edge = (m_len == 0) ? cyc + 1 + ML + 2 : -1;
        end
      end else begin
        if (acc) begin
          m_sum += longint'(in_a) * longint'(in_b);
          m_beats++;
          if (m_beats == m_len) m_valid_edge = cyc + ML + 2;
        end
        if (cyc == m_valid_edge) begin
          m_busy  = 0;
          m_pulse = 1;
          m_res   = m_sum % 65536;
          m_ovf   = OVF_EN && (m_sum >= 65536);
        end
      end
      m_ready = m_busy && (cyc >= m_start + 1) && (m_beats < m_len);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge a_reset_n);
    modelStep();
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    checkOutput("busy", longint'(busy), longint'(m_busy));
    checkOutput("in_ready", longint'(in_ready), longint'(m_ready));
    checkOutput("res_valid", longint'(res_valid), longint'(m_pulse));
    checkOutput("res_data", longint'(res_data), m_res);
    if (!m_busy) checkOutput("ovf", longint'(ovf), longint'(m_ovf));
  end

  logic [DW-1:0] ops_a [16];
  logic [DW-1:0] ops_b [16];
  int job_start = 0;

  task automatic startJob(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = LW'(l);
    @(negedge clk);
    start = 1'b0;
    job_start = m_start;
  endtask

  // Drive n_beats of a len=l job; gap<0 selects random bubbles of 0..2
  // cycles; a start strobe with len=5 is pulsed on beat restart_at.
  task automatic applyStimulus(input int l, input int n_beats, input int gap, input int restart_at);
    int g;
    startJob(l);
    for (int i = 0; i < n_beats; i++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_a     = ops_a[i];
      in_b     = ops_b[i];
      if (i == restart_at) begin
        start = 1'b1;
        len   = LW'(5);
      end
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checkOutput("ready_timeout", 0, 1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = -1;
    for (int g = 0; g < 200; g++) begin
      if (res_valid) begin
        lat = cyc - job_start;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) checkOutput("result_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_in_ready", longint'(in_ready), 0);
    checkOutput("rst_res_valid", longint'(res_valid), 0);
    checkOutput("rst_res_data", longint'(res_data), 0);
    checkOutput("rst_ovf", longint'(ovf), 0);
  endtask

  task automatic setTest1Ops();
    ops_a[0] = 8'h0F; ops_b[0] = 8'h1A;
    ops_a[1] = 8'h26; ops_b[1] = 8'h05;
    ops_a[2] = 8'h03; ops_b[2] = 8'h11;
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    @(posedge clk); #2 a_reset_n = 1'b1;

    // 1: three pairs, no bubbles
    setTest1Ops();
    applyStimulus(3, 3, 0, -1);
    waitResult(lat);
    checkOutput("t1_sum", longint'(res_data), 64'h0277);
    checkOutput("t1_latency", lat, 7);
    checkOutput("t1_ovf", longint'(ovf), 0);

    // 2: same pairs, two bubble cycles between beats
    applyStimulus(3, 3, 2, -1);
    waitResult(lat);
    checkOutput("t2_sum", longint'(res_data), 64'h0277);
    checkOutput("t2_latency", lat, 11);

    // 3: empty job
    applyStimulus(0, 0, 0, -1);
    waitResult(lat);
    checkOutput("t3_sum", longint'(res_data), 0);
    checkOutput("t3_latency", lat, 4);

    // 4: accumulator wrap
    ops_a[0] = 8'hFF; ops_b[0] = 8'hFF;
    ops_a[1] = 8'hFF; ops_b[1] = 8'hFF;
    applyStimulus(2, 2, 0, -1);
    waitResult(lat);
    checkOutput("t4_sum", longint'(res_data), 64'hFC02);
    checkOutput("t4_latency", lat, 6);
    checkOutput("t4_ovf", longint'(ovf), longint'(OVF_EN));

    // 5: start strobe while running is ignored
    setTest1Ops();
    applyStimulus(3, 3, 0, 1);
    waitResult(lat);
    checkOutput("t5_sum", longint'(res_data), 64'h0277);
    checkOutput("t5_latency", lat, 7);
    repeat (3) @(negedge clk);
    checkOutput("t5_idle_after", longint'(busy), 0);

    // 6: reset after two of three beats, then a fresh one-beat job
    applyStimulus(3, 2, 0, -1);
    #2 a_reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkResetOutputs();
    end
    @(posedge clk); #2 a_reset_n = 1'b1;
    ops_a[0] = 8'h02; ops_b[0] = 8'h03;
    applyStimulus(1, 1, 0, -1);
    waitResult(lat);
    checkOutput("t6_sum", longint'(res_data), 64'h0006);
    checkOutput("t6_latency", lat, 5);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int l;
      int rs;
      l = int'($urandom_range(0, 12));
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ops_a[i] = DW'($urandom_range(8'hF0, 8'hFF));
          ops_b[i] = DW'($urandom_range(8'hF0, 8'hFF));
        end else begin
          ops_a[i] = DW'($urandom);
          ops_b[i] = DW'($urandom);
        end
      end
      rs = ($urandom_range(0, 3) == 0 && l > 0) ? int'($urandom_range(0, l - 1)) : -1;
      applyStimulus(l, l, -1, rs);
      waitResult(lat);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
